// File: rtl/acq_sequencer.sv
// rtl/acq_sequencer.sv - ADC acquisition sequencer: decimation, edge trigger, circular pre/post capture
module acq_sequencer #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 12,
  parameter int PRE_TRIG = 256,
  parameter int TO_SHIFT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  input  logic [11:0]       count_adc,
  input  logic [11:0]       trigger,
  input  logic [11:0]       trig_clk,
  input  logic              run,
  input  logic              frame_ack,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              frame_ready,
  output logic [ADDR_W-1:0] start_addr,
  output logic              auto_trig,
  output logic              busy
);
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int POST_N = DEPTH - PRE_TRIG;
  // wide enough for trig_clk << TO_SHIFT, so a saturated counter always meets the limit
  localparam int TO_W   = 12 + TO_SHIFT;
  localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_TRIG - 1);
  localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(POST_N - 1);
  localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRE_TRIG);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRETRIG,
    S_ARMED,
    S_POSTTRIG,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] start_addr_q, start_addr_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [11:0]       dec_cnt_q, dec_cnt_d;
  logic [11:0]       n_q, n_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              wr_en_q, wr_en_d;
  logic              frame_ready_q, frame_ready_d;
  logic              auto_trig_q, auto_trig_d;
  logic              busy_q, busy_d;

  logic              active;
  logic              dec_hit;
  logic              strobe;
  logic              level_hit;
  logic              timeout;
  logic              go_pretrig;
  logic [DATA_W-1:0] trig_lvl;
  logic [TO_W-1:0]   to_limit;

  assign trig_lvl  = DATA_W'(trigger);
  assign to_limit  = TO_W'(trig_clk) << TO_SHIFT;
  assign active    = (state_q == S_PRETRIG) || (state_q == S_ARMED) || (state_q == S_POSTTRIG);
  assign dec_hit   = (dec_cnt_q == n_q - 12'd1);
  assign strobe    = active && adc_valid && dec_hit;
  // PRETRIG always loads prev_q before ARMED, so the level test never sees the reset value
  assign level_hit = (prev_q < trig_lvl) && (adc_data >= trig_lvl);
  assign timeout   = (trig_clk != 12'd0) && (to_cnt_q >= to_limit);

  // next-state and next-output computation for the capture sequencer
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    pre_cnt_d     = pre_cnt_q;
    post_cnt_d    = post_cnt_q;
    wr_addr_d     = wr_addr_q;
    start_addr_d  = start_addr_q;
    to_cnt_d      = to_cnt_q;
    dec_cnt_d     = dec_cnt_q;
    n_d           = n_q;
    prev_d        = prev_q;
    wr_data_d     = wr_data_q;
    wr_en_d       = 1'b0;
    frame_ready_d = frame_ready_q;
    auto_trig_d   = auto_trig_q;
    go_pretrig    = 1'b0;

    if (active && adc_valid) begin
      dec_cnt_d = dec_hit ? 12'd0 : dec_cnt_q + 12'd1;
    end

    if (strobe) begin
      wr_en_d   = 1'b1;
      wr_addr_d = ptr_q;
      wr_data_d = adc_data;
      ptr_d     = ptr_q + ADDR_W'(1);
      prev_d    = adc_data;
    end

    unique case (state_q)
      S_IDLE: begin
        if (run) go_pretrig = 1'b1;
      end
      S_PRETRIG: begin
        if (strobe) begin
          pre_cnt_d = pre_cnt_q + ADDR_W'(1);
          if (pre_cnt_q == PRE_LAST) state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (to_cnt_q != '1) to_cnt_d = to_cnt_q + TO_W'(1);
        // the trigger sample itself is the first post-trigger sample
        if (strobe && (level_hit || timeout)) begin
          start_addr_d = ptr_q - PRE_OFS;
          auto_trig_d  = ~level_hit;
          post_cnt_d   = ADDR_W'(1);
          if (POST_N == 1) begin
            state_d       = S_DONE;
            frame_ready_d = 1'b1;
          end else begin
            state_d = S_POSTTRIG;
          end
        end
      end
      S_POSTTRIG: begin
        if (strobe) begin
          post_cnt_d = post_cnt_q + ADDR_W'(1);
          if (post_cnt_q == POST_LAST) begin
            state_d       = S_DONE;
            frame_ready_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (frame_ack) begin
          frame_ready_d = 1'b0;
          if (run) go_pretrig = 1'b1;
          else     state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // every new frame starts from address 0 with a freshly latched decimation ratio
    if (go_pretrig) begin
      state_d     = S_PRETRIG;
      ptr_d       = '0;
      pre_cnt_d   = '0;
      post_cnt_d  = '0;
      to_cnt_d    = '0;
      dec_cnt_d   = 12'd0;
      auto_trig_d = 1'b0;
      n_d         = (count_adc == 12'd0) ? 12'd1 : count_adc;
    end

    busy_d = (state_d != S_IDLE);
  end

  // state and registered outputs, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      pre_cnt_q     <= '0;
      post_cnt_q    <= '0;
      wr_addr_q     <= '0;
      start_addr_q  <= '0;
      to_cnt_q      <= '0;
      dec_cnt_q     <= 12'd0;
      n_q           <= 12'd1;
      prev_q        <= '0;
      wr_data_q     <= '0;
      wr_en_q       <= 1'b0;
      frame_ready_q <= 1'b0;
      auto_trig_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      pre_cnt_q     <= pre_cnt_d;
      post_cnt_q    <= post_cnt_d;
      wr_addr_q     <= wr_addr_d;
      start_addr_q  <= start_addr_d;
      to_cnt_q      <= to_cnt_d;
      dec_cnt_q     <= dec_cnt_d;
      n_q           <= n_d;
      prev_q        <= prev_d;
      wr_data_q     <= wr_data_d;
      wr_en_q       <= wr_en_d;
      frame_ready_q <= frame_ready_d;
      auto_trig_q   <= auto_trig_d;
      busy_q        <= busy_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign frame_ready = frame_ready_q;
  assign start_addr  = start_addr_q;
  assign auto_trig   = auto_trig_q;
  assign busy        = busy_q;

endmodule
